// File: rtl/nubusdefs.sv
// Shared NuBus card definitions: memory-arbiter state encoding, owner codes and
// the default memory-access timeout.
package nubusdefs;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_SLV      = 2'd1,
        ARB_CPU      = 2'd2,
        ARB_CPU_LOCK = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_SLV = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    localparam int unsigned NUBUS_MEM_TIMEOUT = 255;

endpackage

// File: rtl/nubus_watchdog.sv
// Cycle counter that flags when TIMEOUT-1 counted cycles have elapsed since the
// last clear. Shared by the memory arbiter and the NuBus master bus-timeout.
module nubus_watchdog
    import nubusdefs::*;
#(
    parameter int unsigned TIMEOUT = NUBUS_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // The owner is always dropped at LAST, so the count never needs to wrap or saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/nubus_mem_arbiter.sv
// Round-robin arbiter sharing the card memory port between the NuBus slave path
// and the local processor, with processor lock and a memory-stall watchdog.
module nubus_mem_arbiter
    import nubusdefs::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = NUBUS_MEM_TIMEOUT
) (
    input  logic            nub_clkn,
    input  logic            nub_resetn,
    input  logic            slv_valid,
    input  logic [AW-1:0]   slv_addr,
    input  logic [DW-1:0]   slv_wdata,
    input  logic [DW/8-1:0] slv_wstrb,
    output logic            slv_ready,
    output logic            slv_err,
    output logic [DW-1:0]   slv_rdata,
    input  logic            cpu_valid,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_wstrb,
    input  logic            cpu_lock,
    output logic            cpu_ready,
    output logic            cpu_err,
    output logic [DW-1:0]   cpu_rdata,
    output logic            mem_valid,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic            gnt_slv_o,
    output logic            gnt_cpu_o
);

    arb_state_e r_state, w_state_next;
    owner_e     r_last, w_last_next;
    logic       w_grant;
    logic       w_expired;
    logic       w_done;
    logic       w_abort;

    assign mem_valid = ((r_state == ARB_SLV) && slv_valid) || ((r_state == ARB_CPU) && cpu_valid);
    assign w_done    = mem_valid && mem_ready;
    // Ready wins over a timeout landing in the same cycle.
    assign w_abort   = mem_valid && !mem_ready && w_expired;

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            r_state <= ARB_IDLE;
            r_last  <= OWN_CPU;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_grant      = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                // On a tie the requester not granted last wins.
                if (slv_valid && (!cpu_valid || (r_last == OWN_CPU))) begin
                    w_state_next = ARB_SLV;
                    w_last_next  = OWN_SLV;
                    w_grant      = 1'b1;
                end else if (cpu_valid) begin
                    w_state_next = ARB_CPU;
                    w_last_next  = OWN_CPU;
                    w_grant      = 1'b1;
                end
            end
            ARB_SLV: begin
                if (!slv_valid || w_done || w_abort) begin
                    w_state_next = ARB_IDLE;
                end
            end
            ARB_CPU: begin
                if (!cpu_valid || w_abort) begin
                    w_state_next = ARB_IDLE;
                end else if (w_done) begin
                    w_state_next = cpu_lock ? ARB_CPU_LOCK : ARB_IDLE;
                end
            end
            ARB_CPU_LOCK: begin
                // Releasing the lock yields to the slave before any further CPU access.
                if (!cpu_lock) begin
                    w_state_next = ARB_IDLE;
                end else if (cpu_valid) begin
                    w_state_next = ARB_CPU;
                    w_grant      = 1'b1;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (r_state == ARB_SLV) begin
            mem_addr  = slv_addr;
            mem_wdata = slv_wdata;
            mem_wstrb = slv_wstrb;
        end else if (r_state == ARB_CPU) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
        end
    end

    assign slv_ready = w_done && (r_state == ARB_SLV);
    assign cpu_ready = w_done && (r_state == ARB_CPU);
    assign slv_err   = w_abort && (r_state == ARB_SLV);
    assign cpu_err   = w_abort && (r_state == ARB_CPU);
    assign slv_rdata = slv_ready ? mem_rdata : '0;
    assign cpu_rdata = cpu_ready ? mem_rdata : '0;
    assign gnt_slv_o = (r_state == ARB_SLV);
    assign gnt_cpu_o = (r_state == ARB_CPU) || (r_state == ARB_CPU_LOCK);

    nubus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (nub_clkn),
        .rst_n      (nub_resetn),
        .i_clear    (w_grant),
        .i_count_en (mem_valid && !mem_ready),
        .o_expired  (w_expired)
    );

endmodule
